// File: rtl/mvm_stream_loader.sv
// Streams an N x N matrix (row-major) then an N-element vector into packed
// MSB-first buses, pulses mvm_ena once per frame and waits for mvm_done.
module mvm_stream_loader #(
  parameter int N     = 3,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   mvm_ena,
  output logic [N*N*WIDTH-1:0]   mvm_matrix_a,
  output logic [N*WIDTH-1:0]     mvm_vector_b,
  input  logic                   mvm_done,
  output logic                   busy
);

  localparam int MAT_W = N * N * WIDTH;
  localparam int VEC_W = N * WIDTH;
  localparam int CNT_W = $clog2(N * N + 1);
  localparam logic [CNT_W-1:0] TERM_A = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] TERM_B = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    START,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               ena_q, ena_d;
  logic               accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mat_d    = mat_q;
    vec_d    = vec_q;
    ena_d    = 1'b0;
    in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    accept   = in_valid && in_ready;

    case (state_q)
      LOAD_A: begin
        if (accept) begin
          mat_d = (mat_q << WIDTH) | MAT_W'(in_data);
          if (cnt_q == TERM_A) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          vec_d = (vec_q << WIDTH) | VEC_W'(in_data);
          if (cnt_q == TERM_B) begin
            cnt_d   = '0;
            state_d = START;
            // ena is registered so it is high exactly while state is START
            ena_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mvm_done) begin
          state_d = LOAD_A;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      mat_q   <= '0;
      vec_q   <= '0;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
      vec_q   <= vec_d;
      ena_q   <= ena_d;
    end
  end

  assign mvm_ena      = ena_q;
  assign mvm_matrix_a = mat_q;
  assign mvm_vector_b = vec_q;
  assign busy         = rst_n && ((state_q == START) || (state_q == WAIT_DONE));

endmodule

// File: tb/tb_mvm_stream_loader.sv
// Scoreboard bench: driver pushes expected frames, a monitor checks each
// mvm_ena pulse against them; a behavioural multiplier answers with mvm_done.
module tb_mvm_stream_loader;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int NE = N * N + N;
  localparam int MW = N * N * W;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          mvm_ena;
  logic [MW-1:0] mvm_matrix_a;
  logic [VW-1:0] mvm_vector_b;
  logic          mvm_done;
  logic          busy;
  logic          done_resp = 1'b0;
  logic          done_force;

  assign mvm_done = done_resp | done_force;

  mvm_stream_loader #(.N(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mvm_ena      (mvm_ena),
    .mvm_matrix_a (mvm_matrix_a),
    .mvm_vector_b (mvm_vector_b),
    .mvm_done     (mvm_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] mat;
    logic [VW-1:0] vec;
    logic [VW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fa[N*N];
  int   fb[N];
  int   cyc = 0;
  int   last_acc = -10;
  int   done_delay = 3;
  int   resp_cnt = -1;
  bit   prev_ena = 1'b0;

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: element k of the stream lands in slot k counted from the MSB end.
  function automatic exp_t build_exp();
    exp_t e;
    int   s;
    e.mat = '0;
    e.vec = '0;
    e.c   = '0;
    for (int k = 0; k < N * N; k++) e.mat[(N*N-1-k)*W +: W] = W'(fa[k]);
    for (int k = 0; k < N; k++) e.vec[(N-1-k)*W +: W] = W'(fb[k]);
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < N; j++) s += fa[i*N+j] * fb[j];
      e.c[(N-1-i)*W +: W] = W'(s);
    end
    return e;
  endfunction

  // Product as the downstream multiplier would see it from the packed buses.
  function automatic logic [VW-1:0] mult(input logic [MW-1:0] m, input logic [VW-1:0] v);
    logic [VW-1:0]       r;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    int                  s;
    r = '0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < N; j++) begin
        x = m[(N*N-1-(i*N+j))*W +: W];
        y = v[(N-1-j)*W +: W];
        s += int'(x) * int'(y);
      end
      r[(N-1-i)*W +: W] = W'(s);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) last_acc = cyc;
    cyc++;
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mvm_ena) begin
      chk("ena_latency", MW'(cyc), MW'(last_acc + 1));
      chk("ena_width", MW'(prev_ena), MW'(0));
      chk("busy_at_ena", MW'(busy), MW'(1));
      if (exp_q.size() == 0) begin
        chk("unexpected_ena", MW'(1), MW'(0));
      end else begin
        e = exp_q.pop_front();
        chk("matrix_a", mvm_matrix_a, e.mat);
        chk("vector_b", MW'(mvm_vector_b), MW'(e.vec));
        chk("vector_c", MW'(mult(mvm_matrix_a, mvm_vector_b)), MW'(e.c));
      end
    end
    prev_ena = rst_n && mvm_ena;
  end

  // Behavioural multiplier: raises mvm_done for one cycle, done_delay cycles after ena
  always @(negedge clk) begin
    done_resp = 1'b0;
    if (!rst_n) resp_cnt = -1;
    else if (mvm_ena) resp_cnt = done_delay - 1;
    else if (resp_cnt > 0) resp_cnt--;
    else if (resp_cnt == 0) begin
      done_resp = 1'b1;
      resp_cnt  = -1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N * N; k++) fa[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < N; k++) fb[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  // mode 0: valid every cycle, 1: valid toggles 1,0,1,..., 2: random gaps
  task automatic send_frame(input int mode, input int nelem, input bit push, output int cycles);
    int  t;
    int  k;
    bit  v;
    bit  tog;
    bit  acc;
    cycles = 0;
    if (push) exp_q.push_back(build_exp());
    t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready) begin
      chk("wait_ready_timeout", MW'(in_ready), MW'(1));
      return;
    end
    k   = 0;
    tog = 1'b1;
    while (k < nelem && cycles < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      tog      = !tog;
      in_valid = v;
      in_data  = v ? ((k < N * N) ? W'(fa[k]) : W'(fb[k-N*N])) : W'($urandom);
      acc      = v && in_ready;
      step();
      cycles++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    if (k < nelem) chk("load_timeout", MW'(k), MW'(nelem));
  endtask

  initial begin
    int   cyc_used;
    int   t;
    exp_t held;

    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'h5A;
    done_force = 1'b0;
    step();
    repeat (2) begin
      step();
      chk("reset_busy", MW'(busy), MW'(0));
      chk("reset_ena", MW'(mvm_ena), MW'(0));
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("reset_ready", MW'(in_ready), MW'(1));
    chk("reset_matrix", mvm_matrix_a, MW'(0));
    chk("reset_vector", MW'(mvm_vector_b), MW'(0));

    // 1..9 then 1,2,3 continuous, then the same frame with toggling valid
    fa = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    fb = '{1, 2, 3};
    send_frame(0, NE, 1'b1, cyc_used);
    chk("continuous_cycles", MW'(cyc_used), MW'(NE));
    send_frame(1, NE, 1'b1, cyc_used);
    chk("toggle_cycles", MW'(cyc_used), MW'(2 * NE - 1));

    // Next frame's data held valid while waiting 10 cycles for mvm_done
    done_delay = 10;
    rand_frame();
    held = build_exp();
    send_frame(0, NE, 1'b1, cyc_used);
    rand_frame();
    in_valid = 1'b1;
    in_data  = W'(fa[0]);
    t = 0;
    while (!mvm_done && t < 40) begin
      chk("stall_ready", MW'(in_ready), MW'(0));
      chk("stall_matrix", mvm_matrix_a, held.mat);
      step();
      t++;
    end
    chk("stall_len_ge10", MW'(t >= 10), MW'(1));
    step();
    chk("ready_after_done", MW'(in_ready), MW'(1));
    send_frame(0, NE, 1'b1, cyc_used);
    done_delay = 3;

    // Reset after 5 matrix accepts discards the partial frame
    rand_frame();
    send_frame(0, 5, 1'b0, cyc_used);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("midload_reset_ready", MW'(in_ready), MW'(1));
    chk("midload_reset_matrix", mvm_matrix_a, MW'(0));
    fa = '{10, -3, 5, -8, 12, 0, 7, 1, -2};
    fb = '{-4, 9, 3};
    send_frame(2, NE, 1'b1, cyc_used);

    // mvm_done held high across two back-to-back frames
    done_force = 1'b1;
    fa = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    fb = '{2, 7, 99};
    send_frame(0, NE, 1'b1, cyc_used);
    fb = '{0, 0, 0};
    send_frame(2, NE, 1'b1, cyc_used);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    repeat (3) step();
    done_force = 1'b0;

    // Randomized frames, gaps and completion delays
    for (int f = 0; f < 6; f++) begin
      done_delay = int'($urandom_range(1, 6));
      rand_frame();
      send_frame(2, NE, 1'b1, cyc_used);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      step();
      t++;
    end
    chk("scoreboard_drained", MW'(exp_q.size()), MW'(0));
    repeat (10) step();
    chk("idle_busy", MW'(busy), MW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_stream_loader.md
MVM_STREAM_LOADER -- requirements
Module: mvm_stream_loader

Interface
REQ-001 Parameter N, default 3: matrix dimension (N×N matrix, N-element vector).
REQ-002 Parameter WIDTH, default 8: signed element width in bits.
REQ-003 clk  input  1  the single clock; all logic is updated on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream element valid.
REQ-006 in_ready  output  1  loader can accept an element this cycle.
REQ-007 in_data  input  WIDTH  signed element: matrix elements first, row-major, then vector elements.
REQ-008 mvm_ena  output  1  one-cycle start pulse to the downstream matrix_vector_multiplier.
REQ-009 mvm_matrix_a  output  N*N*WIDTH  flattened matrix.
REQ-010 mvm_vector_b  output  N*WIDTH  flattened vector.
REQ-011 mvm_done  input  1  completion flag from the multiplier.
REQ-012 busy  output  1  high from the start pulse until mvm_done is seen.

Function
REQ-013 The states SHALL be LOAD_A, LOAD_B, START and WAIT_DONE.
REQ-014 An element SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be a combinational decode: 1 in LOAD_A or LOAD_B, and 0 otherwise.
REQ-016 In LOAD_A, each accept SHALL shift mvm_matrix_a left by WIDTH and place in_data in the low WIDTH bits.
REQ-017 Consequence of REQ-016: after N*N accepts, the first element received occupies the MSBs (row0[0]), matching the multiplier's MSB-first packing.
REQ-018 In LOAD_B, each accept SHALL shift mvm_vector_b in the same way, so the first vector element received ends up as the MSB element b0.
REQ-019 An element counter SHALL count accepts within the current phase, ranging 0..N*N-1 in LOAD_A and 0..N-1 in LOAD_B.
REQ-020 The counter SHALL clear to 0 at each phase change.
REQ-021 On the accept that sets the counter to its terminal count, the state SHALL change: LOAD_A→LOAD_B, and LOAD_B→START.
REQ-022 In START, mvm_ena SHALL be 1 for exactly one cycle, and the state SHALL then go to WAIT_DONE unconditionally.
REQ-023 busy SHALL be 1 in START and in WAIT_DONE.
REQ-024 In WAIT_DONE, the state SHALL stay until mvm_done=1 is sampled, then go to LOAD_A; in_ready rises the following cycle.
REQ-025 mvm_matrix_a and mvm_vector_b SHALL hold constant from entry to START until the first accept of the next frame.
REQ-026 mvm_done SHALL be ignored in LOAD_A, LOAD_B and START.
REQ-027 mvm_done held high across frames SHALL NOT cause more than one exit from WAIT_DONE per frame.
REQ-028 The minimum latency from the last vector accept to mvm_ena=1 SHALL be exactly 1 cycle.
REQ-029 Gaps in in_valid SHALL stall loading without any loss, duplication or reordering of elements.
REQ-030 Elements presented while in_ready=0 SHALL NOT be consumed; upstream holds them.
REQ-031 Data SHALL pass through unmodified: no arithmetic, sign extension or truncation.

Reset
REQ-032 When rst_n=0 at a rising edge: state←LOAD_A, counter←0, mvm_matrix_a←0, mvm_vector_b←0, mvm_ena←0.
REQ-033 When rst_n=0, busy SHALL be 0.
REQ-034 When rst_n=0, no element SHALL be accepted, even with in_valid=1.
REQ-035 Reset SHALL take priority over every transition, including in mid-LOAD and WAIT_DONE.
REQ-036 After reset, a partially loaded frame SHALL be discarded, and the next accept is treated as row0[0].
REQ-037 After reset deassertion, in_ready SHALL be 1 in the first cycle with rst_n=1.

Verification
REQ-038 Stream 1..9 then 1,2,3, in_valid continuous → 12 accepts in 12 cycles; mvm_matrix_a={1,2,3,4,5,6,7,8,9}; mvm_vector_b={1,2,3}; mvm_ena pulses 1 cycle later for 1 cycle. With the multiplier attached, vector_c={14,32,50}.
REQ-039 Same frame with in_valid toggling 1,0,1,0... → identical buses and a single mvm_ena pulse; the pulse comes one cycle after the 12th accept.
REQ-040 in_valid held high with the next frame's data during WAIT_DONE, mvm_done delayed 10 cycles → in_ready=0 and mvm_matrix_a is unchanged for all 10 cycles; loading resumes the cycle after mvm_done.
REQ-041 rst_n=0 for 1 cycle after 5 matrix accepts, then stream {10,-3,5,-8,12,0,7,1,-2},{-4,9,3} → no mvm_ena before the 11th post-reset accept; vector_c={0xCC,0x8C,0xE7}.
REQ-042 mvm_done=1 forced during LOAD_A/LOAD_B → no state change and no extra pulse; the frame completes normally.
REQ-043 Two back-to-back frames (identity × {2,7,99}, then zero vector) → exactly two mvm_ena pulses; results are {2,7,99} then {0,0,0}.
